// File: rtl/chip8_pkg.sv
// rtl/chip8_pkg.sv - shared types and constants for the CHIP-8 operand-read stage
package chip8_pkg;

  typedef logic        u1;
  typedef logic [3:0]  u4;
  typedef logic [4:0]  u5;
  typedef logic [7:0]  u8;
  typedef logic [15:0] u16;

  localparam u5 REG_I    = 5'd16;
  localparam u5 REG_NONE = 5'd31;

  typedef struct packed {
    u8  vx;
    u8  vy;
    u8  vf;
    u16 i;
    u16 op;
    u5  dst1;
    u5  dst2;
  } operand_t;

  localparam operand_t BUNDLE_RESET = '{vx: 8'h00, vy: 8'h00, vf: 8'h00, i: 16'h0000,
                                        op: 16'h0000, dst1: REG_NONE, dst2: REG_NONE};

  // Indices 17..31 map to no scoreboard bit at all.
  function automatic logic [16:0] reg_onehot(input u5 idx);
    logic [16:0] mask;
    mask = '0;
    if (idx <= REG_I) mask[idx] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/chip8_scoreboard.sv
// rtl/chip8_scoreboard.sv - pending-writer mask for V0..VF (bits 0-15) and I (bit 16)
module chip8_scoreboard
  import chip8_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  u5           wb_r1,
  input  u5           wb_r2,
  input  logic        set_en,
  input  u5           set_a,
  input  u5           set_b,
  input  logic        flush,
  output logic [16:0] pending
);

  logic [16:0] pend_q;
  logic [16:0] clr_mask;
  logic [16:0] set_mask;

  assign clr_mask = reg_onehot(wb_r1) | reg_onehot(wb_r2);
  assign set_mask = set_en ? (reg_onehot(set_a) | reg_onehot(set_b)) : 17'd0;

  // Set is applied after clear so a bit both retired and re-claimed stays pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        pend_q <= '0;
    else if (flush) pend_q <= '0;
    else            pend_q <= (pend_q & ~clr_mask) | set_mask;
  end

  assign pending = pend_q;

endmodule

// File: rtl/chip8_operand_read.sv
// rtl/chip8_operand_read.sv - CHIP-8 operand read with writeback forwarding and hazard scoreboard
module chip8_operand_read
  import chip8_pkg::*;
#(
  parameter int FORWARD     = 1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  u4                      in_x,
  input  u4                      in_y,
  input  u1                      in_use_x,
  input  u1                      in_use_y,
  input  u1                      in_use_f,
  input  u1                      in_use_i,
  input  u5                      in_dst1,
  input  u5                      in_dst2,
  input  u16                     in_op,
  input  u8 [15:0]               registers,
  input  u16                     I,
  input  u5                      wb_r1,
  input  u5                      wb_r2,
  input  u8                      wb_val1,
  input  u8                      wb_val2,
  input  u16                     wb_ival,
  input  u1                      flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output u8                      out_vx,
  output u8                      out_vy,
  output u8                      out_vf,
  output u16                     out_i,
  output u16                     out_op,
  output u5                      out_dst1,
  output u5                      out_dst2,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic [16:0] pending;
  logic        src_haz;
  logic        dst_haz;
  logic        hazard;
  logic        accept;
  operand_t    nxt;
  operand_t    cur;

  function automatic logic fwd_hit(input u5 idx, input u5 r1, input u5 r2);
    return (FORWARD != 0) && ((r1 == idx) || (r2 == idx));
  endfunction

  function automatic u8 pick_v(input u4 idx, input u5 r1, input u5 r2,
                               input u8 v1, input u8 v2, input u8 arch);
    if ((FORWARD != 0) && (r1 == {1'b0, idx})) return v1;
    if ((FORWARD != 0) && (r2 == {1'b0, idx})) return v2;
    return arch;
  endfunction

  chip8_scoreboard u_sb (
    .clk     (clk),
    .rst     (rst),
    .wb_r1   (wb_r1),
    .wb_r2   (wb_r2),
    .set_en  (accept),
    .set_a   (in_dst1),
    .set_b   (in_dst2),
    .flush   (flush),
    .pending (pending)
  );

  always_comb begin
    src_haz = 1'b0;
    if (in_use_x && pending[{1'b0, in_x}] && !fwd_hit({1'b0, in_x}, wb_r1, wb_r2)) src_haz = 1'b1;
    if (in_use_y && pending[{1'b0, in_y}] && !fwd_hit({1'b0, in_y}, wb_r1, wb_r2)) src_haz = 1'b1;
    if (in_use_f && pending[15] && !fwd_hit(5'd15, wb_r1, wb_r2))                  src_haz = 1'b1;
    if (in_use_i && pending[16] && !fwd_hit(REG_I, wb_r1, wb_r2))                  src_haz = 1'b1;
    // WAW hazards are never cleared by forwarding: the older write must retire first.
    dst_haz = |(pending & (reg_onehot(in_dst1) | reg_onehot(in_dst2)));
  end

  assign hazard   = src_haz || dst_haz;
  assign in_ready = !hazard && (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    nxt      = BUNDLE_RESET;
    nxt.op   = in_op;
    nxt.dst1 = in_dst1;
    nxt.dst2 = in_dst2;
    if (in_use_x) nxt.vx = pick_v(in_x, wb_r1, wb_r2, wb_val1, wb_val2, registers[in_x]);
    if (in_use_y) nxt.vy = pick_v(in_y, wb_r1, wb_r2, wb_val1, wb_val2, registers[in_y]);
    if (in_use_f) nxt.vf = pick_v(4'hF, wb_r1, wb_r2, wb_val1, wb_val2, registers[15]);
    if (in_use_i) nxt.i  = fwd_hit(REG_I, wb_r1, wb_r2) ? wb_ival : I;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      cur       <= BUNDLE_RESET;
    end else if (accept) begin
      out_valid <= 1'b1;
      cur       <= nxt;
    end else if (flush || out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (in_valid && hazard && !flush && (stall_cnt != {STALL_CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + 1'b1;
  end

  assign out_vx   = cur.vx;
  assign out_vy   = cur.vy;
  assign out_vf   = cur.vf;
  assign out_i    = cur.i;
  assign out_op   = cur.op;
  assign out_dst1 = cur.dst1;
  assign out_dst2 = cur.dst2;

endmodule

// File: tb/tb_chip8_operand_read.sv
// tb/tb_chip8_operand_read.sv - scoreboard bench for chip8_operand_read, FORWARD=1 and FORWARD=0 side by side
module tb_chip8_operand_read;

  typedef struct {
    logic [7:0]  vx;
    logic [7:0]  vy;
    logic [7:0]  vf;
    logic [15:0] i;
    logic [15:0] op;
    logic [4:0]  d1;
    logic [4:0]  d2;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid, flush, out_ready;
  logic [3:0]       in_x, in_y;
  logic             use_x, use_y, use_f, use_i;
  logic [4:0]       dst1, dst2, wb_r1, wb_r2;
  logic [15:0]      op, ireg, wb_ival;
  logic [7:0]       wb_val1, wb_val2;
  logic [15:0][7:0] regs;

  logic        rdy [2];
  logic        ov  [2];
  logic [7:0]  vx  [2];
  logic [7:0]  vy  [2];
  logic [7:0]  vf  [2];
  logic [15:0] oi  [2];
  logic [15:0] oop [2];
  logic [4:0]  d1  [2];
  logic [4:0]  d2  [2];
  logic [15:0] sc  [2];

  chip8_operand_read #(.FORWARD(1), .STALL_CNT_W(16)) dut_fwd (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_x(in_x), .in_y(in_y),
    .in_use_x(use_x), .in_use_y(use_y), .in_use_f(use_f), .in_use_i(use_i),
    .in_dst1(dst1), .in_dst2(dst2), .in_op(op), .registers(regs), .I(ireg),
    .wb_r1(wb_r1), .wb_r2(wb_r2), .wb_val1(wb_val1), .wb_val2(wb_val2), .wb_ival(wb_ival),
    .flush(flush), .out_valid(ov[0]), .out_ready(out_ready), .out_vx(vx[0]), .out_vy(vy[0]),
    .out_vf(vf[0]), .out_i(oi[0]), .out_op(oop[0]), .out_dst1(d1[0]), .out_dst2(d2[0]),
    .stall_cnt(sc[0]));

  chip8_operand_read #(.FORWARD(0), .STALL_CNT_W(16)) dut_nofwd (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_x(in_x), .in_y(in_y),
    .in_use_x(use_x), .in_use_y(use_y), .in_use_f(use_f), .in_use_i(use_i),
    .in_dst1(dst1), .in_dst2(dst2), .in_op(op), .registers(regs), .I(ireg),
    .wb_r1(wb_r1), .wb_r2(wb_r2), .wb_val1(wb_val1), .wb_val2(wb_val2), .wb_ival(wb_ival),
    .flush(flush), .out_valid(ov[1]), .out_ready(out_ready), .out_vx(vx[1]), .out_vy(vy[1]),
    .out_vf(vf[1]), .out_i(oi[1]), .out_op(oop[1]), .out_dst1(d1[1]), .out_dst2(d2[1]),
    .stall_cnt(sc[1]));

  int   errors = 0;
  int   checks = 0;
  bit   pend [2][17];
  bit   slot [2];
  int   exp_stall [2];
  exp_t q0[$];
  exp_t q1[$];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: instruction-level rules over plain arrays.
  function automatic bit wb_hits(input int k);
    return (wb_r1 == k) || (wb_r2 == k);
  endfunction

  function automatic bit m_hazard(input int d);
    bit fw = (d == 0);
    bit h  = 0;
    if (use_x && pend[d][in_x] && !(fw && wb_hits(in_x))) h = 1;
    if (use_y && pend[d][in_y] && !(fw && wb_hits(in_y))) h = 1;
    if (use_f && pend[d][15]   && !(fw && wb_hits(15)))   h = 1;
    if (use_i && pend[d][16]   && !(fw && wb_hits(16)))   h = 1;
    if (dst1 <= 16 && pend[d][dst1]) h = 1;
    if (dst2 <= 16 && pend[d][dst2]) h = 1;
    return h;
  endfunction

  function automatic logic [7:0] m_v(input int d, input int k);
    if (d == 0 && wb_r1 == k) return wb_val1;
    if (d == 0 && wb_r2 == k) return wb_val2;
    return regs[k];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      slot[d] = 0;
      exp_stall[d] = 0;
      for (int b = 0; b < 17; b++) pend[d][b] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic idle();
    in_valid = 0; in_x = 0; in_y = 0; use_x = 0; use_y = 0; use_f = 0; use_i = 0;
    dst1 = 31; dst2 = 31; op = 16'h0; wb_r1 = 31; wb_r2 = 31;
    wb_val1 = 8'h0; wb_val2 = 8'h0; wb_ival = 16'h0; flush = 0; out_ready = 1;
  endtask

  // Called at posedge+1 with inputs driven; returns at the next posedge+1.
  task automatic cycle();
    bit   exp_rdy, consumed, haz, acc;
    exp_t e;
    #1;
    for (int d = 0; d < 2; d++) begin
      haz      = m_hazard(d);
      exp_rdy  = !haz && (!slot[d] || out_ready) && !flush;
      consumed = slot[d] && out_ready;
      acc      = in_valid && exp_rdy;
      chk(d == 0 ? "in_ready_fwd" : "in_ready_nofwd", rdy[d], exp_rdy);
      if (in_valid && haz && !flush && exp_stall[d] != 16'hFFFF) exp_stall[d]++;
      if (acc) begin
        e.vx = use_x ? m_v(d, in_x) : 8'h0;
        e.vy = use_y ? m_v(d, in_y) : 8'h0;
        e.vf = use_f ? m_v(d, 15)   : 8'h0;
        e.i  = use_i ? ((d == 0 && wb_hits(16)) ? wb_ival : ireg) : 16'h0;
        e.op = op; e.d1 = dst1; e.d2 = dst2;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        slot[d] = 1;
      end else if (flush || consumed) begin
        if (flush && slot[d] && !consumed) begin
          if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
        slot[d] = 0;
      end
      for (int b = 0; b < 17; b++) begin
        if (flush) pend[d][b] = 0;
        else begin
          if (wb_hits(b)) pend[d][b] = 0;
          if (acc && (dst1 == b || dst2 == b)) pend[d][b] = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk(d == 0 ? "out_valid_fwd" : "out_valid_nofwd", ov[d], slot[d]);
      chk(d == 0 ? "stall_cnt_fwd" : "stall_cnt_nofwd", sc[d], exp_stall[d]);
    end
  endtask

  // Monitor: pops one expected bundle per completed output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst && ov[d] && out_ready) begin
          if ((d == 0 ? q0.size() : q1.size()) == 0) begin
            chk(d == 0 ? "unexpected_bundle_fwd" : "unexpected_bundle_nofwd", 1, 0);
          end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk(d == 0 ? "bundle_fwd" : "bundle_nofwd",
                {vx[d], vy[d], vf[d], oi[d], oop[d], d1[d], d2[d]},
                {e.vx, e.vy, e.vf, e.i, e.op, e.d1, e.d2});
          end
        end
      end
    end
  end

  function automatic logic [3:0] rnd_idx();
    case ($urandom_range(0, 5))
      0, 1, 2, 3: return 4'($urandom_range(0, 3));
      4:          return 4'd15;
      default:    return 4'($urandom_range(0, 15));
    endcase
  endfunction

  function automatic logic [4:0] rnd_reg(input int none_pct);
    int r = $urandom_range(0, 99);
    if (r < none_pct)      return 5'd31;
    if (r < none_pct + 10) return 5'd16;
    if (r < none_pct + 14) return 5'($urandom_range(17, 30));
    return {1'b0, rnd_idx()};
  endfunction

  logic [15:0] s0, s1;
  logic [7:0]  held;

  initial begin
    idle();
    regs = '0;
    ireg = 16'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", ov[0], 0);
    chk("rst_stall_cnt", sc[0], 0);
    chk("rst_out_dst1", d1[0], 31);
    chk("rst_out_dst2", d2[1], 31);
    chk("rst_out_vx", vx[0], 0);
    rst = 0;

    // Plain read of V3.
    regs[3] = 8'h5A;
    in_valid = 1; in_x = 3; use_x = 1; op = 16'h8301;
    cycle();
    chk("read_v3", vx[0], 8'h5A);

    // V4 claimed, then read V4: stall until writeback, then bypass (or one more cycle).
    idle(); regs[4] = 8'h11;
    in_valid = 1; dst1 = 4; op = 16'h6499;
    cycle();
    idle(); in_valid = 1; in_x = 4; use_x = 1; op = 16'h8400;
    s0 = sc[0]; s1 = sc[1];
    repeat (3) cycle();
    chk("stall3_fwd", sc[0] - s0, 3);
    chk("stall3_nofwd", sc[1] - s1, 3);
    wb_r1 = 4; wb_val1 = 8'h99;
    cycle();
    chk("fwd_v4", vx[0], 8'h99);
    wb_r1 = 31;
    cycle();
    chk("nofwd_v4", vx[1], 8'h11);

    // Backpressure with a queued input, then release.
    idle(); in_valid = 1; in_x = 2; use_x = 1; regs[2] = 8'h21; out_ready = 0; op = 16'h8200;
    cycle();
    held = vx[0];
    for (int k = 0; k < 4; k++) begin
      regs[2] = 8'($urandom);
      cycle();
      chk("hold_vx", vx[0], held);
    end
    out_ready = 1;
    repeat (3) cycle();

    // Claim I then flush: a following I read goes through without a stall.
    idle(); in_valid = 1; dst1 = 16; op = 16'hA123;
    cycle();
    idle(); flush = 1;
    cycle();
    idle(); in_valid = 1; use_i = 1; ireg = 16'hBEEF; op = 16'hF01E;
    s0 = sc[0];
    cycle();
    chk("flush_no_stall", sc[0], s0);

    // Reset in the middle of a stall with a held bundle.
    idle(); in_valid = 1; dst1 = 5; out_ready = 0;
    cycle();
    idle(); in_valid = 1; in_x = 5; use_x = 1; out_ready = 0;
    repeat (2) cycle();
    rst = 1;
    #1;
    chk("async_rst_out_valid", ov[0], 0);
    chk("async_rst_stall_cnt", sc[1], 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
    idle();

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_x      = rnd_idx();
      in_y      = rnd_idx();
      use_x     = 1'($urandom);
      use_y     = 1'($urandom);
      use_f     = ($urandom_range(0, 3) == 0);
      use_i     = ($urandom_range(0, 3) == 0);
      dst1      = rnd_reg(50);
      dst2      = ($urandom_range(0, 3) == 0) ? dst1 : rnd_reg(70);
      op        = 16'($urandom);
      wb_r1     = rnd_reg(55);
      wb_r2     = rnd_reg(70);
      wb_val1   = 8'($urandom);
      wb_val2   = 8'($urandom);
      wb_ival   = 16'($urandom);
      flush     = ($urandom_range(0, 19) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      ireg      = 16'($urandom);
      for (int k = 0; k < 16; k++) regs[k] = 8'($urandom);
      cycle();
    end

    idle();
    repeat (4) cycle();
    chk("drained_fwd", q0.size(), 0);
    chk("drained_nofwd", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
